spike_event_fifo: RTL and testbench
===================================

Name: spike_event_fifo

Overview:
- Downstream consumer of the delta comparator's 2-bit spike output.
- On each sample strobe it classifies the spike code and tags each real event with a wrapping sample-index timestamp.
- Events are buffered in a small FIFO and drained over a valid/ready handshake to the output serializer / IO stage.
- Reports buffer occupancy and a sticky overflow flag so downstream logic can detect lost events.

Parameters:
- TS_WIDTH, 6, width of the sample-index timestamp counter and of the event timestamp field.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe: spike is valid for the current sample this cycle.
- spike  input  2  comparator code: 00 none, 01 ON (rise), 11 OFF (fall), 10 illegal.
- ev_valid  output  1  head event available.
- ev_ready  input  1  consumer accepts head event this cycle.
- ev_data  output  TS_WIDTH+1  event word {polarity, timestamp}; polarity 1 = OFF, 0 = ON.
- count  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- illegal  output  1  sticky: code 10 was seen on a sample_valid cycle.
- clr_flags  input  1  synchronous clear of overflow and illegal.

Behaviour:
- Reset (async, rst_n=0): ts counter=0, FIFO empty, count=0, ev_valid=0, ev_data=0, overflow=0, illegal=0. Assertion mid-transfer discards all buffered events immediately.
- Timestamp:
  - ts counter advances by 1 on every sample_valid cycle, whatever the spike code.
  - It wraps from 2^TS_WIDTH-1 to 0.
  - An event captures the counter value before that cycle's increment, so the first sample after reset is stamped 0.
- Classification, applied only when sample_valid=1:
  - 01 -> push {0, ts}.
  - 11 -> push {1, ts}.
  - 00 -> no push.
  - 10 -> no push; set illegal.
  - spike is ignored when sample_valid=0.
- Pop: occurs when ev_valid && ev_ready.
- Push when not full: writes the tail entry.
- Push when full:
  - Without a same-cycle pop: the event is dropped, overflow is set, and FIFO contents are unchanged.
  - With a same-cycle pop: both occur, count stays DEPTH, nothing is dropped.
- Simultaneous push and pop at count 1..DEPTH-1: count is unchanged and order is preserved.
- Latency and ordering:
  - No fall-through: a push into an empty FIFO raises ev_valid on the next cycle.
  - Events leave strictly in arrival order.
- Output stability:
  - ev_data and ev_valid are registered.
  - ev_data holds the head entry and must remain stable while ev_valid=1 and ev_ready=0.
  - ev_valid never drops without a pop, except on reset.
- Pointers:
  - Read and write pointers are clog2(DEPTH) bits, wrapping naturally.
  - count is tracked explicitly. Full means count==DEPTH; empty means count==0.
- Sticky flags:
  - overflow and illegal stay set until clr_flags=1 or reset.
  - If clr_flags and a new set condition occur in the same cycle, set wins: the flag remains 1.
- ev_ready while ev_valid=0 has no effect.

Test Plan:
- Reset, then 4 sample_valid strobes with spike=01,00,11,01 and ev_ready=1 -> events {0,0}, {1,2}, {0,3} in order; ev_valid first high on the cycle after the first push; count returns to 0.
- ev_ready=0, 5 ON events on consecutive samples with DEPTH=4 -> count reaches 4; 5th event dropped and overflow=1; draining yields timestamps 0,1,2,3 only.
- FIFO full (count=4), same cycle push ON plus ev_ready=1 -> head popped, new event enqueued, count stays 4, overflow stays 0.
- 70 sample_valid strobes with spike=00 then one 11 (TS_WIDTH=6) -> event {1,6}, showing timestamp wrap at 64.
- spike=10 on sample_valid -> no push, illegal=1. Then clr_flags=1 in the same cycle as another 10 -> illegal remains 1. clr_flags alone next cycle -> illegal=0.
- rst_n asserted asynchronously mid-cycle with count=3 and ev_valid=1 -> ev_valid, count and ev_data go to 0 immediately; after release, the next event is stamped 0.

Source files
------------

// File: rtl/spike_event_fifo_if.sv
// Event-stream bundle between the delta comparator, the spike event FIFO and the
// output serializer. The master modport is the environment side; the slave modport is the FIFO.
interface spike_event_fifo_if #(
  parameter int TS_WIDTH = 6,
  parameter int DEPTH    = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                sample_valid;
  logic [1:0]          spike;
  logic                ev_valid;
  logic                ev_ready;
  logic [TS_WIDTH:0]   ev_data;
  logic [CW-1:0]       count;
  logic                overflow;
  logic                illegal;
  logic                clr_flags;

  modport master (
    output sample_valid, spike, ev_ready, clr_flags,
    input  ev_valid, ev_data, count, overflow, illegal
  );

  modport slave (
    input  sample_valid, spike, ev_ready, clr_flags,
    output ev_valid, ev_data, count, overflow, illegal
  );
endinterface

// File: rtl/spike_event_fifo.sv
// Timestamps ON/OFF spike codes with a wrapping sample index and buffers them in a
// small registered-output FIFO drained over valid/ready, with sticky overflow/illegal flags.
module spike_event_fifo #(
  parameter int TS_WIDTH = 6,
  parameter int DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  spike_event_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TS_WIDTH + 1;

  typedef enum logic [1:0] {
    SPK_NONE = 2'b00,
    SPK_ON   = 2'b01,
    SPK_BAD  = 2'b10,
    SPK_OFF  = 2'b11
  } spike_e;

  logic [EW-1:0]       mem_q [DEPTH];
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ev_valid_q, ev_valid_d;
  logic [EW-1:0]       ev_data_q, ev_data_d;
  logic                overflow_q, overflow_d;
  logic                illegal_q, illegal_d;

  spike_e        code;
  logic          full, pop, push_req, push_ok, bad_code;
  logic [EW-1:0] push_word;

  // NOTE: every signal gets a value before any branch, so no latch can be inferred.
  always_comb begin
    code       = spike_e'(bus.spike);
    full       = (count_q == CW'(DEPTH));
    pop        = ev_valid_q && bus.ev_ready;
    push_req   = bus.sample_valid && ((code == SPK_ON) || (code == SPK_OFF));
    bad_code   = bus.sample_valid && (code == SPK_BAD);
    push_ok    = push_req && (!full || pop);
    push_word  = {code == SPK_OFF, ts_q};

    ts_d       = bus.sample_valid ? ts_q + TS_WIDTH'(1) : ts_q;
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);

    // The new head is the word being written only when nothing older survives this cycle.
    ev_valid_d = (count_d != '0);
    ev_data_d  = '0;
    if (ev_valid_d) begin
      if (push_ok && ((count_q - CW'(pop)) == '0)) ev_data_d = push_word;
      else                                         ev_data_d = mem_q[rd_ptr_d];
    end

    overflow_d = (push_req && full && !pop) || (overflow_q && !bus.clr_flags);
    illegal_d  = bad_code || (illegal_q && !bus.clr_flags);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ev_valid_q <= ev_valid_d;
      ev_data_q  <= ev_data_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  // NOTE: storage is not reset; count and ev_valid guarantee stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_data  = ev_data_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_spike_event_fifo.sv
// Bench for spike_event_fifo: queue-based reference model checked every cycle, plus
// directed scenarios whose drained event words are pinned with literal values.
module tb_spike_event_fifo;
  localparam int TS_WIDTH = 6;
  localparam int DEPTH    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_event_fifo_if #(.TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH)) bus ();

  spike_event_fifo #(.TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of event words and integer counters.
  logic [TS_WIDTH:0] mq [$];
  int                m_ts  = 0;
  logic              m_ovf = 1'b0;
  logic              m_ill = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ts  = 0;
      m_ovf = 1'b0;
      m_ill = 1'b0;
    end else begin
      automatic bit pop     = (mq.size() != 0) && bus.ev_ready;
      automatic bit is_ev   = bus.sample_valid && (bus.spike == 2'b01 || bus.spike == 2'b11);
      automatic bit is_full = (mq.size() == DEPTH);
      automatic bit drop    = is_ev && is_full && !pop;
      automatic bit bad     = bus.sample_valid && (bus.spike == 2'b10);
      automatic logic [TS_WIDTH:0] word = {bus.spike == 2'b11, TS_WIDTH'(m_ts)};
      if (pop) void'(mq.pop_front());
      if (is_ev && !drop) mq.push_back(word);
      if (bus.sample_valid) m_ts = (m_ts + 1) % (1 << TS_WIDTH);
      m_ovf = drop ? 1'b1 : (bus.clr_flags ? 1'b0 : m_ovf);
      m_ill = bad  ? 1'b1 : (bus.clr_flags ? 1'b0 : m_ill);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ev_valid", 32'(bus.ev_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("ev_data", 32'(bus.ev_data), 32'(mq[0]));
      check("count", 32'(bus.count), 32'(mq.size()));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("illegal", 32'(bus.illegal), 32'(m_ill));
    end
  end

  // Log of words the DUT actually handed over, for literal order checks.
  logic [TS_WIDTH:0] log_q [$];
  logic [TS_WIDTH:0] exp_log [$];

  always @(posedge clk) begin
    if (rst_n && bus.ev_valid && bus.ev_ready) log_q.push_back(bus.ev_data);
  end

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(log_q.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < log_q.size()) check({name, "_word"}, 32'(log_q[i]), 32'(exp_log[i]));
    end
    log_q.delete();
    exp_log.delete();
  endtask

  task automatic step(input logic sv, input logic [1:0] sp, input logic rdy, input logic clr);
    bus.sample_valid = sv;
    bus.spike        = sp;
    bus.ev_ready     = rdy;
    bus.clr_flags    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.spike        = 2'b00;
    bus.ev_ready     = 1'b0;
    bus.clr_flags    = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_ev_valid", 32'(bus.ev_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ev_data", 32'(bus.ev_data), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);

    // Basic classification and ordering with a ready consumer.
    step(1'b1, 2'b01, 1'b1, 1'b0);
    check("first_valid", 32'(bus.ev_valid), 32'd1);
    step(1'b1, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b1, 1'b0);
    check("s1_count", 32'(bus.count), 32'd0);
    exp_log = '{7'h00, 7'h42, 7'h03};
    check_log("s1_log");

    // Fill to DEPTH with a stalled consumer; the fifth event is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    check("s2_count", 32'(bus.count), 32'd4);
    check("s2_overflow", 32'(bus.overflow), 32'd1);
    check("s2_hold_data", 32'(bus.ev_data), 32'h00);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    check("s2_stable_data", 32'(bus.ev_data), 32'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b1, 1'b0);
    exp_log = '{7'h00, 7'h01, 7'h02, 7'h03};
    check_log("s2_log");

    // Push into a full FIFO with a simultaneous pop: nothing is lost.
    step(1'b0, 2'b00, 1'b0, 1'b1);
    check("s3_ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    check("s3_full", 32'(bus.count), 32'd4);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    check("s3_count", 32'(bus.count), 32'd4);
    check("s3_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b1, 1'b0);
    exp_log = '{7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
    check_log("s3_log");

    // Timestamp wrap: 70 empty samples, then an OFF event stamped 70 mod 64.
    do_reset();
    for (int i = 0; i < 70; i++) step(1'b1, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, 1'b1, 1'b0);
    exp_log = '{7'h46};
    check_log("s4_log");

    // Illegal code, and set-wins against a simultaneous clear.
    step(1'b1, 2'b10, 1'b1, 1'b0);
    check("s5_ill_set", 32'(bus.illegal), 32'd1);
    check("s5_no_push", 32'(bus.count), 32'd0);
    step(1'b1, 2'b10, 1'b1, 1'b1);
    check("s5_set_wins", 32'(bus.illegal), 32'd1);
    step(1'b0, 2'b00, 1'b1, 1'b1);
    check("s5_cleared", 32'(bus.illegal), 32'd0);
    step(1'b0, 2'b10, 1'b1, 1'b0);
    check("s5_ignored", 32'(bus.illegal), 32'd0);

    // Asynchronous reset in the middle of a cycle with events buffered.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    check("s6_pre_count", 32'(bus.count), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid", 32'(bus.ev_valid), 32'd0);
    check("s6_rst_count", 32'(bus.count), 32'd0);
    check("s6_rst_data", 32'(bus.ev_data), 32'd0);
    #3;
    rst_n = 1'b1;
    log_q.delete();
    step(1'b1, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b00, 1'b1, 1'b0);
    exp_log = '{7'h00};
    check_log("s6_log");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
